contador_seq_ctrl: RTL and testbench
====================================

// Module: contador_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit up-counter datapath. Drives cnt_clr/cnt_en of an
//  external synchronous counter and watches its value. Each run is a fixed
//  number of counting passes from 0 to a programmable limit, with pause,
//  abort and a one-cycle completion pulse. Sits between the control panel
//  logic (start/stop/pause) and the counter instance.
// PARAMETERS
//  WIDTH   4  counter width; width of limit and cnt_val
//  REP_W   4  width of reps and pass_cnt
// PORTS
//  clock     in   1      single system clock; all state updates on posedge
//  reset     in   1      synchronous, active-high reset
//  start     in   1      level-sampled; begins a run when in IDLE
//  stop      in   1      abort the current run
//  pause     in   1      freeze counting while high (RUN only)
//  limit     in   WIDTH  terminal count of each pass, latched at start
//  reps      in   REP_W  passes per run, latched at start; 0 treated as 1
//  cnt_val   in   WIDTH  current value of the controlled counter
//  cnt_clr   out  1      counter synchronous clear (priority over cnt_en)
//  cnt_en    out  1      counter increment enable
//  busy      out  1      high in CLR and RUN
//  done      out  1      one-cycle pulse: run completed normally
//  aborted   out  1      one-cycle pulse: run ended by stop
//  pass_cnt  out  REP_W  index of current pass, 1-based; 0 when idle
// BEHAVIOUR
//  - Counter model: on posedge, cnt_clr=1 -> 0; else cnt_en=1 -> +1.
//  - States: IDLE, CLR, RUN, DONE, ABORT. Outputs decoded from state
//    and registers: cnt_clr=(CLR); cnt_en=(RUN & ~pause & cnt_val!=limit_q);
//    busy=(CLR|RUN); done=(DONE); aborted=(ABORT).
//  - Reset (sync, active high): state IDLE, limit_q=0, reps_q=0, pass_cnt=0;
//    so cnt_clr=0, cnt_en=0, busy=0, done=0, aborted=0. Reset mid-run abandons
//    the run with no done/aborted pulse; counter is left as-is.
//  - IDLE: start=1 -> latch limit_q=limit, reps_q=(reps==0?1:reps),
//    pass_cnt=1, go CLR. stop/pause ignored.
//  - CLR: one cycle, cnt_clr=1 -> RUN. pause ignored. stop -> ABORT.
//  - RUN, priority order: stop -> ABORT; pause -> hold (no match check);
//    cnt_val==limit_q -> if pass_cnt==reps_q go DONE, else pass_cnt+1, go CLR;
//    otherwise stay RUN with cnt_en=1.
//  - DONE / ABORT: one cycle each, pass_cnt cleared to 0 -> IDLE.
//    start in these states is ignored (no back-to-back start before IDLE).
//  - start while busy ignored; limit/reps changes after start have no effect.
//  - Timing, start sampled at edge k, no pause: CLR in cycle k+1, counter=0
//    at k+2; pass length L+2 cycles (1 CLR + L+1 RUN); done high in cycle
//    k+N*(L+2)+1, N=reps_q, L=limit_q. cnt_en high L cycles per pass.
//  - limit=0: each pass is CLR then one RUN cycle with cnt_en=0.
//  - cnt_en never asserted while cnt_val==limit_q: counter never wraps
//    past 2^WIDTH-1, even with limit=15.
//  - Each pause cycle in RUN extends completion by exactly one cycle.
//  - stop and pause together: stop wins. stop with match: stop wins.
// TESTING
//  1. reset; start@k, limit=3, reps=1 -> cnt_clr@k+1, cnt_en k+2..k+4,
//     done only @k+6, busy k+1..k+5, final cnt_val=3.
//  2. limit=2, reps=2 -> pass_cnt 1 then 2, cnt_clr @k+1 and @k+5,
//     done @k+9, no aborted.
//  3. limit=15, reps=1 -> cnt_val reaches 15, cnt_en low there, no wrap to 0,
//     done @k+18.
//  4. limit=5, reps=1, pause high 3 cycles mid-RUN -> cnt_val frozen,
//     cnt_en=0 while paused, done @k+11; stop+pause together -> aborted next.
//  5. stop in RUN @cnt_val=2 -> aborted pulse 1 cycle later, busy=0,
//     pass_cnt=0, no done; new start accepted only in IDLE.
//  6. reset asserted mid-RUN -> next cycle all outputs 0, IDLE; reps=0 run
//     behaves as reps=1; limit=0 run gives done @k+3.

Source files
------------

// File: rtl/contador_seq_ctrl.sv
// Run sequencer for an external synchronous up-counter: clears it, counts each
// pass up to a latched limit, repeats for a latched number of passes, reports done/abort.
module contador_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] limit,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [REP_W-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] pass_q, pass_d;
    logic             clr_q, busy_q, done_q, abort_q;
    logic             match;

    assign match = (cnt_val == limit_q);

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        reps_d  = reps_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    limit_d = limit;
                    reps_d  = (reps == '0) ? REP_W'(1) : reps;
                    pass_d  = REP_W'(1);
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = stop ? S_ABORT : S_RUN;
            end
            S_RUN: begin
                // Pause holds the state and suppresses the terminal-count check.
                if (stop) begin
                    state_d = S_ABORT;
                end else if (!pause && match) begin
                    if (pass_q == reps_q) begin
                        state_d = S_DONE;
                    end else begin
                        pass_d  = pass_q + REP_W'(1);
                        state_d = S_CLR;
                    end
                end
            end
            S_DONE, S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_DONE || state_d == S_ABORT) begin
            pass_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            limit_q <= '0;
            reps_q  <= '0;
            pass_q  <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            reps_q  <= reps_d;
            pass_q  <= pass_d;
            clr_q   <= (state_d == S_CLR);
            busy_q  <= (state_d == S_CLR) || (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
            abort_q <= (state_d == S_ABORT);
        end
    end

    // Enable stays combinational so the counter stops exactly at the limit.
    assign cnt_en   = (state_q == S_RUN) && !pause && !match;
    assign cnt_clr  = clr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = abort_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_contador_seq_ctrl.sv
// Randomized scoreboard bench: run-level expectations from cycle arithmetic,
// checked by a monitor whenever the sequencer emits a done/aborted pulse.
module tb_contador_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] limit = 4'd0;
    logic [3:0] reps  = 4'd0;
    logic [3:0] cnt_val = 4'd0;
    logic       cnt_clr, cnt_en, busy, done, aborted;
    logic [3:0] pass_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cur_l = 0;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int nbusy;
        int nen;
        int nclr;
        int passes;
    } exp_t;
    exp_t sb[$];

    contador_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .limit(limit), .reps(reps), .cnt_val(cnt_val), .cnt_clr(cnt_clr),
        .cnt_en(cnt_en), .busy(busy), .done(done), .aborted(aborted),
        .pass_cnt(pass_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock cycle, with the external counter modelled around the DUT.
    task automatic tick();
        logic en_s, clr_s;
        @(negedge clock);
        en_s  = cnt_en;
        clr_s = cnt_clr;
        @(posedge clock);
        cyc++;
        #1;
        if (clr_s) cnt_val = 4'd0;
        else if (en_s) cnt_val = cnt_val + 4'd1;
    endtask

    // st: -2 none, -1 stop in CLR, >=0 stop at that RUN offset of pass 1.
    // ro: reset at that RUN offset of pass 1 (-1 none).
    task automatic run(input int l, input int n, input int p, input int po,
                       input int st, input bit sp, input int ro);
        exp_t e;
        int s0, last, neff, fin;
        neff  = (n == 0) ? 1 : n;
        cur_l = l;
        limit = 4'(l);
        reps  = 4'(n);
        start = 1'b1;
        s0 = cyc + 1;
        if (ro < 0) begin
            if (st == -2) begin
                e.kind = 0; e.cyc = s0 + neff * (l + 2) + p; e.cnt = l;
                e.nbusy = e.cyc - s0; e.nen = neff * l; e.nclr = neff; e.passes = neff;
            end else if (st == -1) begin
                e.kind = 1; e.cyc = s0 + 1; e.cnt = 0;
                e.nbusy = 1; e.nen = 0; e.nclr = 1; e.passes = 1;
            end else begin
                fin = sp ? st : ((st < l) ? st + 1 : l);
                e.kind = 1; e.cyc = s0 + st + 2; e.cnt = fin;
                e.nbusy = st + 2; e.nen = fin; e.nclr = 1; e.passes = 1;
            end
            sb.push_back(e);
            last = e.cyc;
        end else begin
            last = s0 + 1 + ro;
        end
        $display("run L=%0d N=%0d P=%0d@%0d stop=%0d sp=%0d rst=%0d", l, n, p, po, st, sp, ro);
        tick();
        start = 1'b0;
        while (cyc <= last) begin
            start = (cyc == s0) || (cyc == last && ro < 0);
            limit = 4'($urandom);
            reps  = 4'($urandom);
            stop  = (st == -1 && cyc == s0) || (st >= 0 && cyc == s0 + 1 + st);
            if (cyc == s0) pause = 1'($urandom);
            else pause = (p > 0 && cyc >= s0 + 1 + po && cyc <= s0 + po + p) ||
                         (sp && st >= 0 && cyc == s0 + 1 + st);
            reset = (ro >= 0 && cyc == last);
            tick();
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; reset = 1'b0;
        if (ro >= 0)
            chk("reset_mid_run_outputs", int'({cnt_clr, cnt_en, busy, done, aborted, pass_cnt}), 0);
        chk("pending_pulses", sb.size(), 0);
        sb.delete();
        stop  = 1'($urandom);
        pause = 1'($urandom);
        tick();
        stop  = 1'b0;
        pause = 1'b0;
        chk("idle_ignores_stop_pause", int'(busy), 0);
    endtask

    // Monitor: per-run activity counters, compared at each completion pulse.
    initial begin
        int nb, ne, nc, mp;
        exp_t e;
        nb = 0; ne = 0; nc = 0; mp = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                nb = 0; ne = 0; nc = 0; mp = 0;
            end else begin
                if (busy) nb++;
                if (cnt_en) ne++;
                if (cnt_clr) nc++;
                if (busy && int'(pass_cnt) > mp) mp = int'(pass_cnt);
                if (cnt_en && int'(cnt_val) == cur_l)
                    chk("en_at_limit", 1, 0);
                if (done || aborted) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", int'({done, aborted}), 0);
                    end else begin
                        e = sb.pop_front();
                        $display("pulse cyc=%0d done=%0d aborted=%0d cnt=%0d", cyc, done, aborted, cnt_val);
                        chk("pulse_kind", int'(aborted) + 2 * int'(done), e.kind ? 1 : 2);
                        chk("pulse_cycle", cyc, e.cyc);
                        chk("final_cnt_val", int'(cnt_val), e.cnt);
                        chk("busy_cycles", nb, e.nbusy);
                        chk("en_cycles", ne, e.nen);
                        chk("clr_cycles", nc, e.nclr);
                        chk("max_pass_cnt", mp, e.passes);
                        chk("pass_cnt_at_pulse", int'(pass_cnt), 0);
                        chk("busy_at_pulse", int'(busy), 0);
                    end
                    nb = 0; ne = 0; nc = 0; mp = 0;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, l, n, p, po, st;
        bit sp;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", int'({cnt_clr, cnt_en, busy, done, aborted, pass_cnt}), 0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", int'({cnt_clr, cnt_en, busy, done, aborted, pass_cnt}), 0);

        run(3, 1, 0, 0, -2, 0, -1);
        run(2, 2, 0, 0, -2, 0, -1);
        run(15, 1, 0, 0, -2, 0, -1);
        run(5, 1, 3, 2, -2, 0, -1);
        run(5, 1, 0, 0, 2, 1, -1);
        run(5, 1, 0, 0, 2, 0, -1);
        run(7, 2, 0, 0, -2, 0, 3);
        run(4, 0, 0, 0, -2, 0, -1);
        run(0, 1, 0, 0, -2, 0, -1);
        run(0, 3, 0, 0, -2, 0, -1);
        run(6, 1, 0, 0, -1, 0, -1);
        run(4, 1, 0, 0, 4, 0, -1);
        run(9, 3, 2, 9, -2, 0, -1);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            l  = $urandom_range(0, 15);
            n  = $urandom_range(0, 15);
            p  = 0; po = 0; st = -2; sp = 1'b0;
            if (mode <= 5) begin
                p  = $urandom_range(0, 3);
                po = $urandom_range(0, l);
                run(l, n, p, po, -2, 0, -1);
            end else if (mode <= 7) begin
                st = $urandom_range(0, l + 1) - 1;
                sp = (st >= 0) ? 1'($urandom) : 1'b0;
                run(l, n, 0, 0, st, sp, -1);
            end else if (mode == 8) begin
                run(l, n, 0, 0, -2, 0, $urandom_range(0, l));
            end else begin
                run(l, n, 0, 0, -2, 0, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
